// File: rtl/mux_n_1_reg.sv
// Registered N:1 channel mux. Mode 0 picks the channel on Sel; Mode 1 grants the
// valid channels round-robin, starting from the stored pointer.

module mux_n_1_reg_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] ptr,
  output logic             sel_hit,
  output logic             at_ptr
);
  localparam logic [SEL_W-1:0] ID = SEL_W'(IDX);

  assign sel_hit = (sel == ID);
  assign at_ptr  = (ptr == ID);
endmodule

module mux_n_1_reg #(
  parameter int WIDTH = 32,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*WIDTH-1:0] In,
  input  logic [CH-1:0]       In_Valid,
  input  logic [SEL_W-1:0]    Sel,
  input  logic                Mode,
  input  logic                En,
  output logic [WIDTH-1:0]    O,
  output logic                O_Valid,
  output logic [SEL_W-1:0]    O_Ch
);
  logic [CH-1:0][WIDTH-1:0] ch_data;
  logic [CH-1:0]            sel_hot, at_ptr, mask, hi, hi_hot, lo_hot, rr_hot;
  logic [SEL_W-1:0]         ptr, ptr_nxt, rr_k;
  logic [WIDTH-1:0]         sel_data, rr_data;
  logic                     sel_ok, sel_vld, rr_any, seen;

  assign ch_data = In;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    mux_n_1_reg_lane #(.SEL_W(SEL_W), .IDX(g)) u_lane (
      .sel    (Sel),
      .ptr    (ptr),
      .sel_hit(sel_hot[g]),
      .at_ptr (at_ptr[g])
    );
  end

  // Round-robin as two priority passes: lowest valid channel at or above ptr,
  // else wrap to the lowest valid channel overall.
  always_comb begin
    seen = 1'b0;
    mask = '0;
    for (int k = 0; k < CH; k++) begin
      seen    = seen | at_ptr[k];
      mask[k] = seen;
    end
    hi      = In_Valid & mask;
    hi_hot  = hi & (~hi + CH'(1));
    lo_hot  = In_Valid & (~In_Valid + CH'(1));
    rr_hot  = (|hi) ? hi_hot : lo_hot;
    rr_any  = |In_Valid;
    rr_k    = '0;
    rr_data = '0;
    sel_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (rr_hot[k])  rr_k     = rr_k | SEL_W'(k);
      if (rr_hot[k])  rr_data  = rr_data | ch_data[k];
      if (sel_hot[k]) sel_data = sel_data | ch_data[k];
    end
    sel_ok  = |sel_hot;
    sel_vld = |(sel_hot & In_Valid);
    ptr_nxt = rr_hot[CH-1] ? '0 : rr_k + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      O       <= '0;
      O_Valid <= 1'b0;
      O_Ch    <= '0;
      ptr     <= '0;
    end else if (En) begin
      if (!Mode) begin
        // Out-of-range Sel (non power-of-2 CH) yields an empty beat.
        O       <= sel_ok ? sel_data : '0;
        O_Valid <= sel_vld;
        O_Ch    <= sel_ok ? Sel : '0;
      end else if (rr_any) begin
        O       <= rr_data;
        O_Valid <= 1'b1;
        O_Ch    <= rr_k;
        ptr     <= ptr_nxt;
      end else begin
        O_Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_n_1_reg.sv
// Directed bench for mux_n_1_reg: a CH=4 instance and an odd CH=3 instance.
module tb_mux_n_1_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] in4;
  logic [3:0]   iv4;
  logic [1:0]   sel4;
  logic         mode4, en4;
  logic [31:0]  o4;
  logic         ov4;
  logic [1:0]   och4;

  logic [95:0]  in3;
  logic [2:0]   iv3;
  logic [1:0]   sel3;
  logic         mode3, en3;
  logic [31:0]  o3;
  logic         ov3;
  logic [1:0]   och3;

  int n_tests = 0;
  int n_fail  = 0;

  mux_n_1_reg #(.WIDTH(32), .CH(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .In(in4), .In_Valid(iv4), .Sel(sel4), .Mode(mode4),
    .En(en4), .O(o4), .O_Valid(ov4), .O_Ch(och4)
  );

  mux_n_1_reg #(.WIDTH(32), .CH(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .In(in3), .In_Valid(iv3), .Sel(sel3), .Mode(mode3),
    .En(en3), .O(o3), .O_Valid(ov3), .O_Ch(och3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in4 = 128'hdead_beef_0bad_f00d_cafe_babe_1234_5678;
    iv4 = 4'b1111; sel4 = 2'd2; mode4 = 1'b1; en4 = 1'b1;
    in3 = 96'hffff_ffff_eeee_eeee_dddd_dddd;
    iv3 = 3'b111; sel3 = 2'd1; mode3 = 1'b0; en3 = 1'b0;
    tick(); tick();
    rst = 1'b0; en4 = 1'b0;
    tick();
    chk("rst_o",  o4, 32'h0);
    chk("rst_ov", {31'b0, ov4}, 32'h0);
    chk("rst_ch", {30'b0, och4}, 32'h0);
    chk("rst_o3", o3, 32'h0);

    // Mode 0 sweep
    for (int k = 0; k < 4; k++) in4[k*32 +: 32] = 32'h1111_1111 * (k + 1);
    iv4 = 4'b1111; mode4 = 1'b0; en4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel4 = 2'(k);
      tick();
      chk("m0_o",  o4, 32'h1111_1111 * (k + 1));
      chk("m0_ch", {30'b0, och4}, k);
      chk("m0_ov", {31'b0, ov4}, 32'h1);
    end
    iv4 = 4'b1101; sel4 = 2'd1;
    tick();
    chk("m0_inv_ov", {31'b0, ov4}, 32'h0);
    chk("m0_inv_o",  o4, 32'h2222_2222);

    // Round robin, ptr still 0
    mode4 = 1'b1; iv4 = 4'b1011;
    begin
      int exp_ch [4] = '{0, 1, 3, 0};
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("rr_ch", {30'b0, och4}, exp_ch[i]);
        chk("rr_ov", {31'b0, ov4}, 32'h1);
      end
    end
    // ptr = 1: capture ch2, then go empty
    iv4 = 4'b0100;
    tick();
    chk("e_cap", {30'b0, och4}, 32'd2);
    iv4 = 4'b0000;
    tick();
    chk("e_ov", {31'b0, ov4}, 32'h0);
    chk("e_o",  o4, 32'h3333_3333);
    chk("e_ch", {30'b0, och4}, 32'd2);
    iv4 = 4'b1111;
    tick();
    chk("e_next", {30'b0, och4}, 32'd3);
    chk("e_nov",  {31'b0, ov4}, 32'h1);

    // Stall: ptr = 0, outputs hold ch3
    en4 = 1'b0; mode4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel4 = 2'(i);
      in4[32 +: 32] = 32'hdead_0000 + i;
      tick();
      chk("st_o",  o4, 32'h4444_4444);
      chk("st_ch", {30'b0, och4}, 32'd3);
    end
    en4 = 1'b1; sel4 = 2'd1; in4[32 +: 32] = 32'hdead_beef;
    tick();
    chk("st_go", o4, 32'hdead_beef);
    chk("st_gch", {30'b0, och4}, 32'd1);

    // Ptr persists across a Mode 0 beat
    mode4 = 1'b1;
    tick();
    chk("p_rr0", {30'b0, och4}, 32'd0);
    mode4 = 1'b0; sel4 = 2'd3;
    tick();
    chk("p_m0", {30'b0, och4}, 32'd3);
    mode4 = 1'b1;
    tick();
    chk("p_rr1", {30'b0, och4}, 32'd1);
    // Reset mid-sequence restarts at channel 0, even with En low
    rst = 1'b1; en4 = 1'b0;
    tick();
    rst = 1'b0; en4 = 1'b1;
    tick();
    chk("r_ch", {30'b0, och4}, 32'd0);
    chk("r_o",  o4, 32'h1111_1111);

    // Odd CH = 3
    for (int k = 0; k < 3; k++) in3[k*32 +: 32] = 32'ha0a0_0000 + k;
    iv3 = 3'b111; en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1;
    tick();
    chk("o3_sel1", o3, 32'ha0a0_0001);
    sel3 = 2'd3;
    tick();
    chk("o3_oor_o",  o3, 32'h0);
    chk("o3_oor_ov", {31'b0, ov3}, 32'h0);
    chk("o3_oor_ch", {30'b0, och3}, 32'h0);
    mode3 = 1'b1;
    begin
      int exp3 [4] = '{0, 1, 2, 0};
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("o3_rr", {30'b0, och3}, exp3[i]);
        chk("o3_rro", o3, 32'ha0a0_0000 + exp3[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
